// File: rtl/instr_dcd_core_if.sv
// Bus between the SPI byte deserializer, the instruction decoder and the register bank.
// The decoder attaches through the slave modport.
interface instr_dcd_core_if;
    logic       byte_sync;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       read;
    logic       write;
    logic [5:0] addr;
    logic [7:0] data_read;
    logic [7:0] data_write;

    modport master (
        output byte_sync, data_in, data_read,
        input  data_out, read, write, addr, data_write
    );

    modport slave (
        input  byte_sync, data_in, data_read,
        output data_out, read, write, addr, data_write
    );
endinterface

// File: rtl/instr_dcd_core.sv
// SPI instruction decoder: 2-byte frames (setup byte, data byte) into register bank strobes.
// Optional S_DATA idle timeout enabled by defining INSTR_DCD_TIMEOUT_EN.
//
// state   | meaning
// S_SETUP | waiting for setup byte (RW, HL, address)
// S_DATA  | setup latched, waiting for data / dummy byte
module instr_dcd_core
`ifdef INSTR_DCD_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 255
)
`endif
(
    input logic               clk,
    input logic               rst,
    instr_dcd_core_if.slave   bus
);

    typedef enum logic {S_SETUP = 1'b0, S_DATA = 1'b1} state_t;

    state_t     state_q, state_d;
    logic       rw_q, rw_d;
    logic       hl_q, hl_d;
    logic [5:0] addr_q, addr_d;
    logic [7:0] data_write_q, data_write_d;
    logic [7:0] data_out_q, data_out_d;
    logic       read_q, read_d;
    logic       write_q, write_d;
    logic       timeout;

`ifdef INSTR_DCD_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Down-counter loaded on entry to S_DATA; terminal count after TIMEOUT_CYCLES idle clocks.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_SETUP && bus.byte_sync) begin
            cnt_d = CNT_W'(TIMEOUT_CYCLES - 1);
        end else if (state_q == S_DATA && !bus.byte_sync && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign timeout = (state_q == S_DATA) && !bus.byte_sync && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_SETUP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_SETUP: if (bus.byte_sync) state_d = S_DATA;
            S_DATA:  if (bus.byte_sync || timeout) state_d = S_SETUP;
            default: state_d = S_SETUP;
        endcase
    end

    always_comb begin
        rw_d         = rw_q;
        hl_d         = hl_q;
        addr_d       = addr_q;
        data_write_d = data_write_q;
        data_out_d   = data_out_q;
        read_d       = 1'b0;
        write_d      = 1'b0;
        if (bus.byte_sync) begin
            case (state_q)
                S_SETUP: begin
                    rw_d   = bus.data_in[7];
                    hl_d   = bus.data_in[6];
                    addr_d = bus.data_in[5:0];
                end
                S_DATA: begin
                    if (rw_q) begin
                        write_d      = 1'b1;
                        data_write_d = bus.data_in;
                    end else begin
                        // Read frame: the second byte is a dummy, bank data is captured instead.
                        read_d     = 1'b1;
                        data_out_d = bus.data_read;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rw_q         <= 1'b0;
            hl_q         <= 1'b0;
            addr_q       <= '0;
            data_write_q <= '0;
            data_out_q   <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
        end else begin
            rw_q         <= rw_d;
            hl_q         <= hl_d;
            addr_q       <= addr_d;
            data_write_q <= data_write_d;
            data_out_q   <= data_out_d;
            read_q       <= read_d;
            write_q      <= write_d;
        end
    end

    assign bus.addr       = addr_q;
    assign bus.data_write = data_write_q;
    assign bus.data_out   = data_out_q;
    assign bus.read       = read_q;
    assign bus.write      = write_q;

endmodule

// File: tb/tb_instr_dcd_core.sv
// Scoreboard bench for instr_dcd_core: stimulus pushes expected strobes, a negedge monitor pops and checks.
module tb_instr_dcd_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    instr_dcd_core_if bus ();

    instr_dcd_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [5:0] a;
        logic [7:0] d;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mem    [64];
    logic [7:0] shadow [64];

    assign bus.data_read = mem[bus.addr];

    always @(posedge clk) begin
        if (!rst && bus.write) mem[bus.addr] <= bus.data_write;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (bus.read || bus.write)) begin
            exp_t e;
            if (bus.read && bus.write) begin
                check("strobe_exclusive", 32'd1, 32'd0);
            end else if (sb.size() == 0) begin
                check("unexpected_strobe", {bus.read, bus.write}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("strobe_kind", bus.write, e.wr);
                check("strobe_addr", bus.addr, e.a);
                if (e.wr) check("data_write", bus.data_write, e.d);
                else      check("data_out", bus.data_out, e.d);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bus.byte_sync = 1'b1;
        bus.data_in   = b;
        @(posedge clk);
        #1;
        bus.byte_sync = 1'b0;
        bus.data_in   = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] setup, input logic [7:0] dbyte, input int gap);
        exp_t e;
        e.wr = setup[7];
        e.a  = setup[5:0];
        if (setup[7]) begin
            e.d = dbyte;
            shadow[setup[5:0]] = dbyte;
        end else begin
            e.d = shadow[setup[5:0]];
        end
        sb.push_back(e);
        send_byte(setup);
        if (gap > 0) idle(gap);
        send_byte(dbyte);
    endtask

    task automatic drain(input string name);
        int budget = 5;
        while (sb.size() != 0 && budget > 0) begin
            idle(1);
            budget--;
        end
        check(name, sb.size(), 32'd0);
    endtask

    initial begin
        bus.byte_sync = 1'b0;
        bus.data_in   = 8'h00;
        for (int i = 0; i < 64; i++) begin
            mem[i]    = 8'(i * 7 + 3);
            shadow[i] = 8'(i * 7 + 3);
        end
        mem[7]     = 8'h11; shadow[7]  = 8'h11;
        mem[20]    = 8'hCD; shadow[20] = 8'hCD;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_addr", bus.addr, 32'd0);
        check("rst_data_out", bus.data_out, 32'd0);
        check("rst_data_write", bus.data_write, 32'd0);
        check("rst_read", bus.read, 32'd0);
        check("rst_write", bus.write, 32'd0);

        frame(8'h83, 8'hA5, 0);
        drain("t1_write");
        check("t1_hold_data_write", bus.data_write, 32'hA5);

        frame(8'h8C, 8'hFF, 1);
        drain("t2_write");

        frame(8'h07, 8'h00, 0);
        drain("t3_read");
        idle(2);
        check("t3_data_out_hold", bus.data_out, 32'h11);
        check("t3_read_low", bus.read, 32'd0);

        frame(8'h54, 8'h00, 2);
        drain("t4_read_hl");
        check("t4_addr_hold", bus.addr, 32'd20);

        send_byte(8'h83);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_rst_addr", bus.addr, 32'd0);
        check("t5_rst_data_out", bus.data_out, 32'd0);
        check("t5_rst_data_write", bus.data_write, 32'd0);
        frame(8'h05, 8'h00, 0);
        drain("t5_read_after_rst");

        for (int i = 0; i < 10; i++) begin
            logic [5:0] a;
            logic [7:0] d;
            a = 6'($urandom_range(0, 63));
            d = 8'($urandom_range(0, 255));
            frame({2'b10, a}, d, int'($urandom_range(0, 2)));
            frame({1'b0, 1'($urandom_range(0, 1)), a}, 8'($urandom_range(0, 255)),
                  int'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        drain("t6_random");

`ifdef INSTR_DCD_TIMEOUT_EN
        send_byte(8'h85);
        idle(260);
        frame(8'h06, 8'h00, 0);
        drain("t7_timeout");
`endif

        idle(3);
        check("final_queue_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
